// File: rtl/bfly_pair_feeder_pkg.sv
// Shared constants and types for the radix-2 FFT datapath: sample width,
// default butterfly span, complex sample type and the FILL/PAIR encoding.
package bfly_pair_feeder_pkg;

    localparam int CPLX_WIDTH = 16;
    localparam int LOG2D_DEF  = 3;

    // Counter MSB doubles as the phase flag: low half of a block fills, high half pairs
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_PAIR = 1'b1;

    typedef struct packed {
        logic [CPLX_WIDTH-1:0] re;
        logic [CPLX_WIDTH-1:0] im;
    } cplx_t;

    function automatic int bfly_span(input int log2d);
        return 1 << log2d;
    endfunction

endpackage

// File: rtl/bfly_pair_feeder_if.sv
// Sample stream in, butterfly operand pairs out. The master drives samples,
// the slave (the feeder) drives pairs and the sop error pulse.
interface bfly_pair_feeder_if
    import bfly_pair_feeder_pkg::*;
#(
    parameter int WIDTH = CPLX_WIDTH,
    parameter int LOG2D = LOG2D_DEF
);

    logic             in_valid;
    logic             in_sop;
    logic [WIDTH-1:0] in_re;
    logic [WIDTH-1:0] in_im;

    logic [WIDTH-1:0] a_re;
    logic [WIDTH-1:0] a_im;
    logic [WIDTH-1:0] b_re;
    logic [WIDTH-1:0] b_im;
    logic [LOG2D-1:0] tw_idx;
    logic             pair_valid;
    logic             pair_last;
    logic             sop_err;

    modport master (
        output in_valid, in_sop, in_re, in_im,
        input  a_re, a_im, b_re, b_im, tw_idx, pair_valid, pair_last, sop_err
    );

    modport slave (
        input  in_valid, in_sop, in_re, in_im,
        output a_re, a_im, b_re, b_im, tw_idx, pair_valid, pair_last, sop_err
    );

endinterface

// File: rtl/bfly_pair_feeder_cplx_buf.sv
// First-half sample store: simple dual-port RAM with synchronous write and an
// enabled registered read. No reset so it maps onto block/distributed RAM.
module bfly_pair_feeder_cplx_buf
    import bfly_pair_feeder_pkg::*;
#(
    parameter int DATA_W = 2 * CPLX_WIDTH,
    parameter int ADDR_W = LOG2D_DEF
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register only loads on a pair, so the a operand holds between pairs
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bfly_pair_feeder.sv
// Radix-2 butterfly feeder: buffers the first D samples of each 2*D block and
// pairs sample k with sample k+D, tagging each pair with twiddle index k.
module bfly_pair_feeder
    import bfly_pair_feeder_pkg::*;
#(
    parameter int WIDTH = CPLX_WIDTH,
    parameter int LOG2D = LOG2D_DEF
) (
    input  logic               clk,
    input  logic               rst,
    bfly_pair_feeder_if.slave  bus
);

    localparam logic [LOG2D-1:0] LAST_IDX = '1;
    localparam logic [LOG2D:0]   CNT_ONE  = {{LOG2D{1'b0}}, 1'b1};

    logic [LOG2D:0]     cnt;
    logic [LOG2D-1:0]   idx;
    logic [0:0]         state;

    logic               sop_take;
    logic               fill_take;
    logic               pair_take;

    logic               buf_wr_en;
    logic [LOG2D-1:0]   buf_wr_addr;
    logic [2*WIDTH-1:0] buf_rd_data;

    logic               a_live;
    logic [WIDTH-1:0]   b_re_q;
    logic [WIDTH-1:0]   b_im_q;
    logic [LOG2D-1:0]   tw_idx_q;
    logic               pair_valid_q;
    logic               pair_last_q;
    logic               sop_err_q;

    assign idx   = cnt[LOG2D-1:0];
    assign state = cnt[LOG2D];

    // A start-of-packet sample always restarts the block at index 0, whatever the phase
    assign sop_take  = bus.in_valid & bus.in_sop;
    assign fill_take = bus.in_valid & ~bus.in_sop & (state == ST_FILL);
    assign pair_take = bus.in_valid & ~bus.in_sop & (state == ST_PAIR);

    assign buf_wr_en   = sop_take | fill_take;
    assign buf_wr_addr = sop_take ? '0 : idx;

    bfly_pair_feeder_cplx_buf #(
        .DATA_W (2 * WIDTH),
        .ADDR_W (LOG2D)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_wr_en),
        .wr_addr (buf_wr_addr),
        .wr_data ({bus.in_re, bus.in_im}),
        .rd_en   (pair_take),
        .rd_addr (idx),
        .rd_data (buf_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (sop_take) begin
            cnt <= CNT_ONE;
        end else if (bus.in_valid) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_live       <= 1'b0;
            b_re_q       <= '0;
            b_im_q       <= '0;
            tw_idx_q     <= '0;
            pair_valid_q <= 1'b0;
            pair_last_q  <= 1'b0;
            sop_err_q    <= 1'b0;
        end else begin
            pair_valid_q <= pair_take;
            pair_last_q  <= pair_take && (idx == LAST_IDX);
            sop_err_q    <= sop_take && (cnt != '0);
            if (pair_take) begin
                a_live   <= 1'b1;
                b_re_q   <= bus.in_re;
                b_im_q   <= bus.in_im;
                tw_idx_q <= idx;
            end
        end
    end

    // The RAM read register has no reset, so a is forced to zero until the first pair
    assign bus.a_re       = a_live ? buf_rd_data[2*WIDTH-1:WIDTH] : '0;
    assign bus.a_im       = a_live ? buf_rd_data[WIDTH-1:0]       : '0;
    assign bus.b_re       = b_re_q;
    assign bus.b_im       = b_im_q;
    assign bus.tw_idx     = tw_idx_q;
    assign bus.pair_valid = pair_valid_q;
    assign bus.pair_last  = pair_last_q;
    assign bus.sop_err    = sop_err_q;

endmodule

// File: tb/tb_bfly_pair_feeder.sv
// Self-checking bench for bfly_pair_feeder: a block-level queue model predicts
// pairs and sop errors with their arrival cycle; a monitor compares every cycle.
module tb_bfly_pair_feeder;
    import bfly_pair_feeder_pkg::*;

    localparam int W = 16;
    localparam int L = 2;
    localparam int D = 1 << L;

    typedef struct {
        int           stamp;
        logic [W-1:0] ar;
        logic [W-1:0] ai;
        logic [W-1:0] br;
        logic [W-1:0] bi;
        logic [L-1:0] tw;
        logic         last;
    } pair_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bfly_pair_feeder_if #(.WIDTH(W), .LOG2D(L)) bus();

    bfly_pair_feeder #(.WIDTH(W), .LOG2D(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    cplx_t blk[$];
    pair_t pair_q[$];
    int    err_q[$];
    pair_t hold;

    function automatic pair_t zeroPair();
        pair_t p;
        p.stamp = 0;
        p.ar = '0; p.ai = '0; p.br = '0; p.bi = '0;
        p.tw = '0; p.last = 1'b0;
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    // The reference keeps the current block as a list of samples; once more than
    // D are held, each new sample pairs with the one D positions earlier.
    task automatic modelSample(input logic sop, input logic [W-1:0] re, input logic [W-1:0] im);
        cplx_t s;
        pair_t p;
        int    n;
        if (sop) begin
            if (blk.size() != 0) err_q.push_back(cyc + 1);
            blk.delete();
        end
        s.re = re;
        s.im = im;
        blk.push_back(s);
        n = blk.size();
        if (n > D) begin
            p.stamp = cyc + 1;
            p.ar    = blk[n-1-D].re;
            p.ai    = blk[n-1-D].im;
            p.br    = re;
            p.bi    = im;
            p.tw    = L'(n - 1 - D);
            p.last  = (n == 2 * D);
            pair_q.push_back(p);
        end
        if (n == 2 * D) blk.delete();
    endtask

    task automatic applyStimulus(input logic valid, input logic sop, input logic [W-1:0] re, input logic [W-1:0] im);
        @(negedge clk);
        bus.in_valid = valid;
        bus.in_sop   = sop;
        bus.in_re    = re;
        bus.in_im    = im;
        if (valid) modelSample(sop, re, im);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_a_re",       32'(bus.a_re),       32'd0);
        checkOutput("rst_a_im",       32'(bus.a_im),       32'd0);
        checkOutput("rst_b_re",       32'(bus.b_re),       32'd0);
        checkOutput("rst_b_im",       32'(bus.b_im),       32'd0);
        checkOutput("rst_tw_idx",     32'(bus.tw_idx),     32'd0);
        checkOutput("rst_pair_valid", 32'(bus.pair_valid), 32'd0);
        checkOutput("rst_pair_last",  32'(bus.pair_last),  32'd0);
        checkOutput("rst_sop_err",    32'(bus.sop_err),    32'd0);
    endtask

    task automatic applyReset();
        applyStimulus(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        #2 rst = 1'b1;
        blk.delete();
        hold = zeroPair();
        #1 checkResetOutputs();
        @(negedge clk);
        checkResetOutputs();
        #2 rst = 1'b0;
    endtask

    logic mon_pv;
    logic mon_err;

    always @(negedge clk) begin
        if (!rst) begin
            mon_pv = (pair_q.size() > 0) && (pair_q[0].stamp == cyc);
            if (mon_pv) hold = pair_q.pop_front();
            checkOutput("pair_valid", 32'(bus.pair_valid), 32'(mon_pv));
            checkOutput("pair_last",  32'(bus.pair_last),  32'(mon_pv && hold.last));
            checkOutput("a_re",       32'(bus.a_re),       32'(hold.ar));
            checkOutput("a_im",       32'(bus.a_im),       32'(hold.ai));
            checkOutput("b_re",       32'(bus.b_re),       32'(hold.br));
            checkOutput("b_im",       32'(bus.b_im),       32'(hold.bi));
            checkOutput("tw_idx",     32'(bus.tw_idx),     32'(hold.tw));
            mon_err = (err_q.size() > 0) && (err_q[0] == cyc);
            if (mon_err) void'(err_q.pop_front());
            checkOutput("sop_err",    32'(bus.sop_err),    32'(mon_err));
        end
    end

    initial begin
        logic v;
        logic s;
        hold         = zeroPair();
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_re    = '0;
        bus.in_im    = '0;
        @(negedge clk);
        #1 checkResetOutputs();
        @(negedge clk);
        #2 rst = 1'b0;

        $display("[TB] single ramp block");
        for (int k = 0; k < 2 * D; k++) applyStimulus(1'b1, k == 0, W'(k), W'(100 + k));

        $display("[TB] two back-to-back random blocks");
        for (int k = 0; k < 4 * D; k++) applyStimulus(1'b1, (k % (2 * D)) == 0, W'($urandom), W'($urandom));

        $display("[TB] gapped ramp with stray sop on idle cycles");
        for (int k = 0; k < 2 * D; k++) begin
            applyStimulus(1'b1, k == 0, W'(k), W'(100 + k));
            applyStimulus(1'b0, 1'b1, W'($urandom), W'($urandom));
        end

        $display("[TB] sop mid-block");
        for (int k = 0; k < D + 1; k++) applyStimulus(1'b1, k == 0, W'(30 + k), W'(130 + k));
        for (int k = 0; k < 2 * D; k++) applyStimulus(1'b1, k == 0, W'(50 + k), W'(150 + k));

        $display("[TB] reset mid-block");
        for (int k = 0; k < D + 2; k++) applyStimulus(1'b1, k == 0, W'(60 + k), W'(160 + k));
        applyReset();
        for (int k = 0; k < 2 * D; k++) applyStimulus(1'b1, 1'b0, W'(20 + k), W'(120 + k));

        $display("[TB] extreme values");
        for (int k = 0; k < 2 * D; k++) begin
            if (k < D) applyStimulus(1'b1, k == 0, 16'h8000, 16'hFFFF);
            else       applyStimulus(1'b1, 1'b0,   16'h7FFF, 16'h0001);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(3, 0) != 0);
            if (blk.size() == 0) s = $urandom_range(1, 0) != 0;
            else                 s = ($urandom_range(24, 0) == 0);
            applyStimulus(v, s, W'($urandom), W'($urandom));
        end

        repeat (3) applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("pairs_pending",   32'(pair_q.size()), 32'd0);
        checkOutput("sop_err_pending", 32'(err_q.size()),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bfly_pair_feeder.md
# bfly_pair_feeder

Upstream feeder for the radix-2 butterfly stage. Accepts a serial stream of complex samples, buffers the first half of each 2·D-sample block, then emits aligned operand pairs (a = sample k, b = sample k+D) with twiddle index k, one pair per accepted second-half sample. It sits between the previous FFT stage (or input adapter) and the butterfly/twiddle-ROM pair.

## Interface
- WIDTH, 16, bits per real/imag component (two's complement)
- LOG2D, 3, log2 of butterfly span D; block length is 2·D = 2^(LOG2D+1)

- clk  in  1  rising-edge clock, single domain
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample present this cycle; no backpressure, accepted unconditionally
- in_sop  in  1  first sample of a block; qualified by in_valid
- in_re, in_im  in  WIDTH each  sample components
- a_re, a_im  out  WIDTH each  first-half operand (sample k)
- b_re, b_im  out  WIDTH each  second-half operand (sample k+D)
- tw_idx  out  LOG2D  twiddle index k (selects W_{2D}^k)
- pair_valid  out  1  a/b/tw_idx valid this cycle
- pair_last  out  1  asserted with pair_valid when tw_idx = D-1
- sop_err  out  1  one-cycle pulse: in_sop seen mid-block

## Operation
- Counter cnt, LOG2D+1 bits, counts accepted samples within a block; state = cnt[LOG2D]: FILL (0) or PAIR (1).
- FILL: accepted sample written to buffer[cnt[LOG2D-1:0]]; no output.
- PAIR: buffer read at cnt[LOG2D-1:0] → a; current sample registered → b; tw_idx = cnt[LOG2D-1:0].
- cnt increments on every in_valid; 2·D-1 wraps to 0 (FILL), so back-to-back blocks need no gap.
- in_valid & in_sop: sample treated as index 0 (written to buffer[0], cnt ← 1). If cnt ≠ 0 at that moment, pulse sop_err next cycle; the partial block is discarded and no further pairs from it are emitted.
- in_sop without in_valid: ignored.
- in_valid low: cnt, state, buffer hold; pair_valid low next cycle.
- No arithmetic on data; values pass bit-exact, no scaling.
- Buffer contents are not reset; stale data is never emitted because PAIR is only reachable after D FILL writes.

## Timing
- Reset values: cnt = 0, state FILL, pair_valid = 0, pair_last = 0, sop_err = 0, a/b/tw_idx = 0.
- Latency: pair for second-half sample accepted in cycle t appears in cycle t+1 (registered b, synchronous buffer read issued in cycle t).
- Outputs held between valid pairs; only pair_valid/pair_last/sop_err are pulses.
- Buffer write and read to the same address in one cycle cannot occur (write only in FILL, read only in PAIR).
- Reset asserted mid-block: outputs and cnt clear immediately (asynchronous); next accepted sample is index 0 regardless of in_sop.
- Throughput: one sample per cycle; D pairs per 2·D samples.

## Structure
- fft_pkg: cplx type/width constants shared with butterfly and twiddle ROM, LOG2D default, FILL/PAIR encoding.
- Sub-module cplx_buf: simple dual-port RAM, D × 2·WIDTH, synchronous write and registered read, no reset; maps to block/distributed RAM.
- Top holds counter, sop handling, output registers.

## Test plan
- D=4, continuous ramp in_re = 0..7, in_im = 100..107, sop on 0 → four pairs (0,4),(1,5),(2,6),(3,7), imag (100,104)…, tw_idx 0..3, pair_last on 4th, each one cycle after b sample.
- Two back-to-back blocks (16 samples, sop on 0 and 8, no gaps) → 8 pairs, second block's tw_idx restarts at 0, no sop_err.
- Ramp 0..7 with in_valid low on every other cycle → same four pairs, pair_valid only the cycle after each accepted PAIR sample, outputs held otherwise.
- in_sop at sample 5 of a block → sop_err pulse, no pair for 5; new block pairs (5',9')…, i.e. restart at tw_idx 0.
- rst asserted after 6 samples, released, new ramp 20..27 → no pairs before 4 new samples; pairs (20,24)…(23,27); all outputs 0 during reset.
- Extremes: a = 0x8000, b = 0x7FFF, imag 0xFFFF/0x0001 → passed bit-exact.
